// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the 3x3 convolution MAC scheduler.
package conv_sched_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned SHIFT_DEF  = 10;
  localparam int unsigned TAPS       = 9;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    NORM,
    OUT
  } state_t;

  // Gaussian-like kernel; taps sum to 1023 so SHIFT=10 keeps unity gain.
  localparam logic [7:0] DEFAULT_COEF [TAPS] = '{
    8'd97,  8'd121, 8'd97,
    8'd121, 8'd151, 8'd121,
    8'd97,  8'd121, 8'd97
  };

endpackage

// File: rtl/conv3x3_mac_sched.sv
// 3x3 convolution sequencer time-sharing one external multiplier over nine taps,
// with coefficient registers, accumulator and round/saturate output stage.
module conv3x3_mac_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   win_valid,
  output logic                   win_ready,
  input  logic [9*DATA_W-1:0]    win_data,
  input  logic                   coef_we,
  input  logic [3:0]             coef_addr,
  input  logic [DATA_W-1:0]      coef_wdata,
  output logic                   coef_err,
  output logic [DATA_W-1:0]      mul_a,
  output logic [DATA_W-1:0]      mul_b,
  input  logic [2*DATA_W-1:0]    mul_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   busy
);

  localparam logic [3:0]   TAP_LAST = 4'(TAPS - 1);
  localparam logic [ACC_W:0] HALF   = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0] PIX_MAX = (ACC_W + 1)'((1 << DATA_W) - 1);

  state_t state, state_next;

  logic [DATA_W-1:0] coef [TAPS];
  logic [DATA_W-1:0] pix  [TAPS];
  logic [3:0]        tap;
  logic [3:0]        tap_next;
  logic [ACC_W-1:0]  acc;
  logic              coef_ok;
  logic [DATA_W-1:0] coef0_eff;
  logic [ACC_W:0]    rnd;
  logic [DATA_W-1:0] sat;

  assign coef_ok  = coef_we && (state == IDLE) && (coef_addr <= TAP_LAST);
  assign tap_next = tap + 4'd1;
  // A write landing on the accept edge must reach the first operand too.
  assign coef0_eff = (coef_ok && coef_addr == 4'd0) ? coef_wdata : coef[0];

  always_comb begin
    rnd = ({1'b0, acc} + HALF) >> SHIFT;
    sat = (rnd > PIX_MAX) ? {DATA_W{1'b1}} : rnd[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (win_valid) state_next = MAC;
      MAC:  if (tap == TAP_LAST) state_next = NORM;
      NORM: state_next = OUT;
      OUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    win_ready = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == OUT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        coef[i] <= DATA_W'(DEFAULT_COEF[i]);
        pix[i]  <= '0;
      end
      acc      <= '0;
      tap      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      out_data <= '0;
      coef_err <= 1'b0;
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_ok) coef[coef_addr] <= coef_wdata;

      unique case (state)
        IDLE: begin
          if (win_valid) begin
            for (int unsigned i = 0; i < TAPS; i++)
              pix[i] <= win_data[i*DATA_W +: DATA_W];
            acc   <= '0;
            tap   <= '0;
            mul_a <= win_data[DATA_W-1:0];
            mul_b <= coef0_eff;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(mul_p);
          if (tap == TAP_LAST) begin
            tap   <= '0;
            mul_a <= '0;
            mul_b <= '0;
          end else begin
            tap   <= tap_next;
            mul_a <= pix[tap_next];
            mul_b <= coef[tap_next];
          end
        end
        NORM: out_data <= sat;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/conv3x3_mac_sched.md
# conv3x3_mac_sched

Synthesizable sequencer that computes one 3x3 convolution output per window by time-multiplexing a single external 8x8 multiplier (exact or approximate variant, chosen at the top level) over the nine taps. It sits between the line-buffer/window generator and the output pixel stream. It owns the kernel coefficient registers, the accumulator, and the rounding and saturation stage, and applies valid/ready handshakes on both sides.

## Interface
- DATA_W, 8, pixel and coefficient width
- ACC_W, 20, accumulator width (9·255·255 = 585225 < 2^20)
- SHIFT, 10, normalization right-shift (default kernel sums to 1023)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- win_valid  in  1  window present
- win_ready  out  1  block can accept a window
- win_data  in  9·DATA_W  tap k = win_data[8k+7:8k], k = 3·row + col
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  tap index 0..8; values 9..15 are ignored
- coef_wdata  in  DATA_W  coefficient value
- coef_err  out  1  one-cycle pulse when a write is rejected
- mul_a  out  DATA_W  multiplier operand, pixel (registered)
- mul_b  out  DATA_W  multiplier operand, coefficient (registered)
- mul_p  in  2·DATA_W  combinational product of mul_a·mul_b
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  normalized pixel
- busy  out  1  high in every state except IDLE

## Operation
- On reset:
  - Coefficients load the defaults 97,121,97 / 121,151,121 / 97,121,97.
  - State goes to IDLE.
  - win_ready=1; out_valid=0; out_data=0; mul_a=mul_b=0; acc=0; coef_err=0; busy=0.
- FSM states: IDLE, MAC, NORM, OUT.
- IDLE:
  - win_ready=1.
  - When win_valid is high, latch win_data, clear acc, set tap=0, load mul_a=pix[0] and mul_b=coef[0], then go to MAC.
- MAC:
  - Each cycle, acc += mul_p (zero-extended to ACC_W). Then tap++ and load the operands for the next tap.
  - After tap 8 is accumulated, go to NORM.
- NORM:
  - r = (acc + 2^(SHIFT-1)) >> SHIFT.
  - out_data = r if r ≤ 255, otherwise 255.
  - Go to OUT.
- OUT:
  - out_valid=1.
  - out_data and out_valid stay stable until out_ready is high. On that edge, go to IDLE.
- Coefficient writes:
  - Accepted only in IDLE with coef_addr ≤ 8. The new value takes effect on the next window.
  - A write in any other state, or with coef_addr > 8, is dropped. coef_err pulses on the following cycle.
  - If coef_we and win_valid are both high in IDLE, the write lands first and the window being accepted uses the new coefficient.
- The block never reads mul_p outside MAC. The multiplier sees stable operands for one full cycle per tap.

## Timing
- Window accepted at edge E0, meaning the edge where win_valid and win_ready are both high.
- MAC accumulates at edges E1..E9.
- NORM registers the result at E10. out_valid is high from E10.
- With out_ready held high, the output handshake completes at E11 and win_ready returns after E11.
- Minimum period is 12 cycles per window. win_ready is 0 from E0 until IDLE is re-entered.
- Reset mid-operation aborts the window and drops out_valid on the next edge. No partial result is emitted.

## Structure
- conv_sched_pkg holds:
  - the state enum;
  - the default kernel constant array;
  - the DATA_W, ACC_W and SHIFT defaults;
  - TAPS=9.
- No sub-module. The multiplier is instantiated beside this block at the top level so that the exact and approximate variants can be swapped without touching the scheduler.

## Test plan
All scenarios use an exact multiplier on the bench.
- All pixels 100, default kernel -> out_data=100 (acc=102300). out_valid rises 10 cycles after acceptance.
- All pixels 255, default kernel -> acc=260865, out_data=255.
- All coefficients written to 255, all pixels 255 -> acc=585225, r=572, saturates to out_data=255.
- Centre pixel 200, others 0, default kernel -> acc=30200, out_data=29.
- Hold out_ready low for 5 cycles in OUT, with coef_we pulsed during MAC:
  - out_data and out_valid stay stable and win_ready stays 0;
  - coef_err pulses once and the kernel is unchanged on the next window.
- Assert reset at MAC tap 4 -> out_valid never rises; next cycle win_ready=1 and coefficients are back to defaults.
